input_buffer: RTL and testbench

Flit FIFO for one router input channel. It sits directly downstream of the input flow-control stage: it accepts that stage's `write` strobe and data, and returns `full`, which the flow-control stage reflects upstream as `ret`. Stored flits are presented first-word-fall-through to the routing/arbitration logic, which pops them with `read`. It also reports occupancy, almost-full status and sticky overflow/underflow error flags.

---
 rtl/input_buffer.sv | 103 ++++++++++
 tb/tb_input_buffer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/input_buffer.sv
// input_buffer: flit FIFO for one router input channel.
// Accepts pushes from the input flow-control stage and presents the head flit
// first-word-fall-through to routing/arbitration, which pops it with read.
//
// Ports:
//   clk          in   clock, all state updates on rising edge
//   rst          in   synchronous active-high reset
//   write        in   push request
//   din          in   flit to push (DATA_WIDTH)
//   read         in   pop request
//   dout         out  head flit, zero when empty (DATA_WIDTH)
//   full         out  occupancy == DEPTH
//   empty        out  occupancy == 0
//   almost_full  out  occupancy == DEPTH-1
//   count        out  occupancy 0..DEPTH (ADDR_WIDTH+1)
//   overflow     out  sticky: write seen while full
//   underflow    out  sticky: read seen while empty
module input_buffer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  // Storage and state
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wr_en;
  logic w_rd_en;

  // Status flags decoded from the registered count only, so they never
  // depend combinationally on write/read.
  assign w_full  = (r_cnt == CNT_W'(DEPTH));
  assign w_empty = (r_cnt == CNT_W'(0));

  // Accepts are judged against pre-edge state; a write on full is dropped
  // even when a pop happens in the same cycle.
  assign w_wr_en = write & ~w_full;
  assign w_rd_en = read  & ~w_empty;

  // Flit storage, not reset
  always_ff @(posedge clk) begin
    if (!rst && w_wr_en) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers, occupancy and sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cnt       <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      end
      if (w_wr_en && !w_rd_en) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (w_rd_en && !w_wr_en) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      r_overflow  <= r_overflow  | (write & w_full);
      r_underflow <= r_underflow | (read  & w_empty);
    end
  end

  // Outputs
  assign dout        = w_empty ? '0 : r_mem[r_rd_ptr];
  assign full        = w_full;
  assign empty       = w_empty;
  assign almost_full = (r_cnt == CNT_W'(DEPTH - 1));
  assign count       = r_cnt;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;

endmodule

// File: tb/tb_input_buffer.sv
// Bench for input_buffer: stimulus queues the flits it expects to see popped,
// a negedge monitor compares dout on every accepted pop.
module tb_input_buffer;

  logic        clk;
  logic        rst;
  logic        write;
  logic [31:0] din;
  logic        read;
  logic [31:0] dout;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic [2:0]  count;
  logic        overflow;
  logic        underflow;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] exp_q [$];

  input_buffer #(.DATA_WIDTH(32), .DEPTH(4), .ADDR_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .write(write), .din(din), .read(read),
    .dout(dout), .full(full), .empty(empty), .almost_full(almost_full),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: apply inputs, take the edge, settle 1 time unit past it
  task automatic cyc(input logic w, input logic r, input logic [31:0] d);
    write = w;
    read  = r;
    din   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] d);
    cyc(1'b1, 1'b0, d);
    exp_q.push_back(d);
  endtask

  task automatic status(input string tag, input logic [2:0] c, input logic e,
                        input logic f, input logic af);
    check({tag, " count"}, 32'(count), 32'(c));
    check({tag, " empty"}, 32'(empty), 32'(e));
    check({tag, " full"}, 32'(full), 32'(f));
    check({tag, " almost_full"}, 32'(almost_full), 32'(af));
  endtask

  // Monitor: an accepted pop must present the oldest expected flit
  always @(negedge clk) begin
    if (!rst && read && !empty) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL pop_unexpected: got %0h expected no pop", dout);
      end else begin
        check("pop_dout", dout, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; write = 1'b0; read = 1'b0; din = '0;

    // 1. Reset held 2 cycles with write active
    cyc(1'b1, 1'b0, 32'hAAAA_AAAA);
    cyc(1'b1, 1'b0, 32'hAAAA_AAAA);
    rst = 1'b0;
    write = 1'b0;
    status("reset", 3'd0, 1'b1, 1'b0, 1'b0);
    check("reset dout", dout, 32'h0);
    check("reset overflow", 32'(overflow), 32'h0);
    check("reset underflow", 32'(underflow), 32'h0);

    // 2. Fill and drain
    push_exp(32'h11);
    check("fill1 dout", dout, 32'h11);
    push_exp(32'h22);
    push_exp(32'h33);
    status("fill3", 3'd3, 1'b0, 1'b0, 1'b1);
    push_exp(32'h44);
    status("fill4", 3'd4, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 32'h0);
    status("drain", 3'd0, 1'b1, 1'b0, 1'b0);
    check("drain dout", dout, 32'h0);
    check("drain underflow", 32'(underflow), 32'h0);

    // 3. Overflow: write on full is dropped and flagged
    push_exp(32'h11);
    push_exp(32'h22);
    push_exp(32'h33);
    push_exp(32'h44);
    cyc(1'b1, 1'b0, 32'h55);
    check("ovf count", 32'(count), 32'd4);
    check("ovf flag", 32'(overflow), 32'h1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 32'h0);
    check("ovf sticky", 32'(overflow), 32'h1);
    status("ovf drain", 3'd0, 1'b1, 1'b0, 1'b0);

    // 4. Full with read and write together: only the pop happens
    push_exp(32'd1);
    push_exp(32'd2);
    push_exp(32'd3);
    push_exp(32'd4);
    cyc(1'b1, 1'b1, 32'd5);
    status("full rw", 3'd3, 1'b0, 1'b0, 1'b1);
    check("full rw dout", dout, 32'd2);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 32'h0);
    status("full rw drain", 3'd0, 1'b1, 1'b0, 1'b0);

    // 5. Concurrent push/pop at count 2 across pointer wraps
    push_exp(32'd100);
    push_exp(32'd101);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b1, 32'(102 + i));
      exp_q.push_back(32'(102 + i));
      check("stream count", 32'(count), 32'd2);
    end
    cyc(1'b0, 1'b1, 32'h0);
    cyc(1'b0, 1'b1, 32'h0);
    status("stream drain", 3'd0, 1'b1, 1'b0, 1'b0);
    check("stream leftovers", 32'(exp_q.size()), 32'd0);

    // 6. Empty read + write: push only, underflow set
    cyc(1'b1, 1'b1, 32'd7);
    exp_q.push_back(32'd7);
    check("er count", 32'(count), 32'd1);
    check("er dout", dout, 32'd7);
    check("er underflow", 32'(underflow), 32'h1);
    push_exp(32'd8);
    push_exp(32'd9);
    check("pre-rst count", 32'(count), 32'd3);

    // Mid-operation reset discards stored flits and clears flags
    rst = 1'b1;
    cyc(1'b1, 1'b1, 32'hDEAD_BEEF);
    rst = 1'b0;
    exp_q.delete();
    write = 1'b0;
    read = 1'b0;
    status("mid rst", 3'd0, 1'b1, 1'b0, 1'b0);
    check("mid rst dout", dout, 32'h0);
    check("mid rst overflow", 32'(overflow), 32'h0);
    check("mid rst underflow", 32'(underflow), 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    check("post rst count", 32'(count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
